mux_arbiter: RTL and testbench
==============================

// Module: mux_arbiter
// PURPOSE
//  Round-robin arbiter sharing the 8-bit 2:1 datapath mux between two requesters (A, B).
//  Drives the mux select, issues grants and registers the selected byte into an output stage.
//  The output stage uses a valid/ready handshake.
//  Sits between the register-file/ALU sources and the shared internal bus of the microprocessor.
// PARAMETERS
//  MAX_HOLD   4   max consecutive accepted beats for one owner while the other requests (>=1)
//  CNT_W      3   width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk        in   1  system clock; one clock domain, all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  req_a      in   1  requester A has a byte to send
//  data_a     in   8  requester A byte (mux input A, Sel=0)
//  req_b      in   1  requester B has a byte to send
//  data_b     in   8  requester B byte (mux input B, Sel=1)
//  out_ready  in   1  downstream can take out_data this cycle
//  gnt_a      out  1  A owns the bus (registered)
//  gnt_b      out  1  B owns the bus (registered)
//  sel        out  1  mux select: 0=A, 1=B; equals gnt_b when owned, holds last value in IDLE
//  out_data   out  8  registered selected byte
//  out_valid  out  1  out_data holds an unconsumed byte
// BEHAVIOUR
//  Reset: state=IDLE, gnt_a=gnt_b=0, sel=0, out_data=8'h00, out_valid=0, hold_cnt=0, last=B.
//  Reset mid-transfer drops any byte held in the output stage; no byte is replayed.
//  States: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A), gnt_b=(state==OWN_B); never both high.
//  IDLE: neither req -> IDLE. One req -> that owner. Both -> the owner that is not 'last'.
//    Grant is asserted the cycle after req is first seen (1-cycle grant latency).
//  free = !out_valid | out_ready.
//  accept = owner's req & owner's gnt & free.
//  On accept: out_data <= mux(data_a,data_b,sel) next edge; out_valid <= 1; hold_cnt++.
//  No accept & out_ready: out_valid <= 0. out_data is held while out_valid & !out_ready.
//  Owner X leaves when (!req_X) or (accept & hold_cnt==MAX_HOLD-1 & other req).
//    Other requesting -> goes directly to OWN_other, hold_cnt<=0, last<=X.
//    Otherwise -> IDLE, last<=X.
//  Owner alone keeps the bus indefinitely; hold_cnt saturates at MAX_HOLD-1 and does not wrap.
//  Simultaneous: accept and switch in the same cycle; the accepted byte belongs to the old owner.
//  Back-pressure: while !free no accept occurs and hold_cnt does not advance.
//    Owner keeps the grant unless its req drops.
//  Throughput: 1 byte/cycle with out_ready=1.
//  Latency: req -> gnt 1 cycle; gnt&req -> out_valid 1 cycle.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs cnt_a[7:0], cnt_b[7:0].
//    Each counts accepted beats per requester, saturates at 8'hFF, clears on reset.
//  ARB_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset with req_a=1 -> all outputs at reset values.
//    After release, gnt_a=1 next cycle; sel=0.
//  2 req_a=1 only, data_a=8'h3C, out_ready=1 -> out_valid=1, out_data=8'h3C one cycle after gnt_a.
//    Data streams every cycle.
//  3 req_a=req_b=1 from IDLE after reset, out_ready=1, MAX_HOLD=4 -> 4 beats from A,
//    then gnt_b (sel=1), 4 beats from B, then back to A; strict alternation.
//  4 owner A, out_ready=0 for 5 cycles -> out_data frozen, out_valid=1, hold_cnt static.
//    Resume -> A's remaining beats delivered, none lost or duplicated.
//  5 req_b drops while owning -> IDLE next cycle (req_a=0).
//    With req_a=1 instead -> direct OWN_A, no IDLE cycle.
//  6 ARB_STATS_EN: 300 accepted A beats -> cnt_a=8'hFF, cnt_b unchanged.
//    reset -> both 0.

Source files
------------

// File: rtl/mux_arbiter.sv
//==============================================================================
// mux_arbiter : round-robin owner arbiter for the shared 8-bit 2:1 bus mux,
//               with a registered valid/ready output stage.
// Optional    : ARB_STATS_EN adds per-requester accepted-beat counters.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module mux_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic [7:0] data_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    input  logic       out_ready,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       sel,
    output logic [7:0] out_data,
    output logic       out_valid
`ifdef ARB_STATS_EN
    ,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             last_b;
    logic             free;
    logic             accept;
    logic             hold_last;

    assign free      = !out_valid || out_ready;
    assign accept    = free && (((state == OWN_A) && req_a) || ((state == OWN_B) && req_b));
    assign hold_last = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            sel       <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            last_b    <= 1'b1;
        end else begin
            // Output stage: the accepted byte always belongs to the current owner.
            if (accept) begin
                out_data  <= sel ? data_b : data_a;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (req_a && (!req_b || last_b)) begin
                        state <= OWN_A;
                        gnt_a <= 1'b1;
                        gnt_b <= 1'b0;
                        sel   <= 1'b0;
                    end else if (req_b) begin
                        state <= OWN_B;
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b1;
                        sel   <= 1'b1;
                    end
                end
                OWN_A: begin
                    if (!req_a || (accept && hold_last && req_b)) begin
                        last_b   <= 1'b0;
                        hold_cnt <= '0;
                        gnt_a    <= 1'b0;
                        if (req_b) begin
                            state <= OWN_B;
                            gnt_b <= 1'b1;
                            sel   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept && !hold_last) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                OWN_B: begin
                    if (!req_b || (accept && hold_last && req_a)) begin
                        last_b   <= 1'b1;
                        hold_cnt <= '0;
                        gnt_b    <= 1'b0;
                        if (req_a) begin
                            state <= OWN_A;
                            gnt_a <= 1'b1;
                            sel   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept && !hold_last) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt_a    <= 1'b0;
                    gnt_b    <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating counters of accepted beats, attributed by current owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a <= 8'h00;
            cnt_b <= 8'h00;
        end else if (accept) begin
            if ((state == OWN_A) && (cnt_a != 8'hFF)) cnt_a <= cnt_a + 8'd1;
            if ((state == OWN_B) && (cnt_b != 8'hFF)) cnt_b <= cnt_b + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
//==============================================================================
// tb_mux_arbiter : directed self-checking bench for mux_arbiter.
// Revision       : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b, out_ready;
    logic [7:0] data_a, data_b;
    logic       gnt_a, gnt_b, sel, out_valid;
    logic [7:0] out_data;
`ifdef ARB_STATS_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .out_ready (out_ready),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
`ifdef ARB_STATS_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // gnt_a, gnt_b, sel packed as {a,b,s}
    task automatic chk_gnt(input string tag, input logic [2:0] exp);
        chk(tag, {13'd0, gnt_a, gnt_b, sel}, {13'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_a = 1'b1; req_b = 1'b0; out_ready = 1'b1;
        data_a = 8'h3C; data_b = 8'h00;

        // 1: reset with req_a held
        do_reset();
        reset = 1'b1;
        step();
        chk_gnt("rst_gnt_sel", 3'b000);
        chk("rst_out_data", {8'd0, out_data}, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        reset = 1'b0;
        step();
        chk_gnt("rel_gnt_a", 3'b100);
        chk("rel_no_valid", {15'd0, out_valid}, 16'h0000);

        // 2: A alone streams, keeps bus past MAX_HOLD
        step();
        chk("a_first_valid", {15'd0, out_valid}, 16'h0001);
        chk("a_first_data", {8'd0, out_data}, 16'h003C);
        for (int i = 0; i < 6; i++) begin
            data_a = 8'h40 + 8'(i);
            step();
            chk("a_stream_data", {8'd0, out_data}, {8'd0, 8'h40 + 8'(i)});
            chk_gnt("a_stream_gnt", 3'b100);
        end
        // hold_cnt saturated: next accept with B requesting switches immediately
        req_b = 1'b1; data_a = 8'h55; data_b = 8'hEE;
        step();
        chk("sat_last_data", {8'd0, out_data}, 16'h0055);
        chk_gnt("sat_switch_b", 3'b011);

        // 3: both requesting from reset -> strict 4/4 alternation
        req_a = 1'b1; req_b = 1'b1;
        do_reset();
        step();
        chk_gnt("both_first_a", 3'b100);
        for (int i = 0; i < 4; i++) begin
            data_a = 8'hA0 + 8'(i);
            step();
            chk("alt_a_data", {8'd0, out_data}, {8'd0, 8'hA0 + 8'(i)});
            chk_gnt("alt_a_gnt", (i < 3) ? 3'b100 : 3'b011);
        end
        for (int i = 0; i < 4; i++) begin
            data_b = 8'hB0 + 8'(i);
            step();
            chk("alt_b_data", {8'd0, out_data}, {8'd0, 8'hB0 + 8'(i)});
            chk_gnt("alt_b_gnt", (i < 3) ? 3'b011 : 3'b100);
        end
        data_a = 8'hA4;
        step();
        chk("alt_a2_data", {8'd0, out_data}, 16'h00A4);
        chk_gnt("alt_a2_gnt", 3'b100);

        // 4: back-pressure freezes output and hold count
        out_ready = 1'b0; data_a = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data", {8'd0, out_data}, 16'h00A4);
            chk("bp_valid", {15'd0, out_valid}, 16'h0001);
            chk_gnt("bp_gnt", 3'b100);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_a = 8'hA5 + 8'(i);
            step();
            chk("resume_data", {8'd0, out_data}, {8'd0, 8'hA5 + 8'(i)});
            chk_gnt("resume_gnt", (i < 2) ? 3'b100 : 3'b011);
        end

        // 5: owner drops request
        req_a = 1'b0; req_b = 1'b0;
        step();
        chk_gnt("drop_idle", 3'b001);
        chk("drop_valid", {15'd0, out_valid}, 16'h0000);
        req_b = 1'b1; data_b = 8'hC1;
        step();
        chk_gnt("idle_to_b", 3'b011);
        step();
        chk("b_single_data", {8'd0, out_data}, 16'h00C1);
        req_b = 1'b0; req_a = 1'b1;
        step();
        chk_gnt("direct_a", 3'b100);
        chk("direct_no_valid", {15'd0, out_valid}, 16'h0000);

`ifdef ARB_STATS_EN
        // 6: counters saturate and clear
        req_a = 1'b1; req_b = 1'b0;
        do_reset();
        chk("stat_rst_a", {8'd0, cnt_a}, 16'h0000);
        step();
        for (int i = 0; i < 300; i++) step();
        chk("stat_sat_a", {8'd0, cnt_a}, 16'h00FF);
        chk("stat_b_zero", {8'd0, cnt_b}, 16'h0000);
        do_reset();
        chk("stat_clr_a", {8'd0, cnt_a}, 16'h0000);
        chk("stat_clr_b", {8'd0, cnt_b}, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
